// File: rtl/play_engine.sv
// play_engine: walks a song ROM note by note, judges one hit per note and tracks score/combo.
// Define PLAY_HISCORE_EN to build the per-user high-score table; otherwise hi_score is 0.
module play_engine #(
    parameter int USER_W      = 3,
    parameter int ADDR_W      = 6,
    parameter int SCORE_W     = 21,
    parameter int TICK_DIV    = 100000,
    parameter int WIN_PERFECT = 8,
    parameter int WIN_GOOD    = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [USER_W-1:0]  user,
    input  logic [1:0]         mode,
    input  logic [ADDR_W-1:0]  song_len,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [7:0]         rom_data,
    input  logic               hit,
    input  logic [3:0]         hit_note,
    output logic [3:0]         cur_note,
    output logic               busy,
    output logic               done,
    output logic [1:0]         judge,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] combo,
    output logic [SCORE_W-1:0] max_combo,
    output logic [SCORE_W-1:0] hi_score
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int EW = 9;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [EW-1:0] WIN_P = EW'(WIN_PERFECT);
    localparam logic [EW-1:0] WIN_G = EW'(WIN_GOOD);
    localparam logic [1:0] J_NONE = 2'b00, J_MISS = 2'b01, J_GOOD = 2'b10, J_PERFECT = 2'b11;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, DONE} state_t;
    state_t state, state_nx, state_n;

    logic [1:0]         mode_r;
    logic [ADDR_W-1:0]  len_r;
    logic [3:0]         length_r;
    logic [3:0]         note_r;
    logic [PW-1:0]      presc;
    logic [EW-1:0]      elapsed;
    logic               judged;
    logic               start_ok, abort_ok, tick, note_end;
    logic [3:0]         len_eff;
    logic [EW-1:0]      dur;
    logic [1:0]         judge_ev, judge_n;
    logic [SCORE_W-1:0] score_n, combo_n, max_n;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input logic [1:0] inc);
        logic [SCORE_W+1:0] sum;
        sum = {2'b00, a} + {{SCORE_W{1'b0}}, inc};
        if (sum[SCORE_W+1:SCORE_W] != 2'b00) return {SCORE_W{1'b1}};
        else return sum[SCORE_W-1:0];
    endfunction

    assign busy     = (state == FETCH) || (state == WAIT) || (state == PLAY);
    assign done     = (state == DONE);
    assign cur_note = note_r;
    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign abort_ok = abort && busy;
    assign tick     = (presc == PRESC_MAX);
    assign len_eff  = (length_r == 4'd0) ? 4'd1 : length_r;
    assign note_end = (state == PLAY) && (elapsed == dur);
    assign state_n  = abort_ok ? IDLE : state_nx;

    // Note duration in ticks, scaled by the latched play mode.
    always_comb begin
        case (mode_r)
            2'b10:   dur = {len_eff, 5'b00000};
            2'b11:   dur = {2'b00, len_eff, 3'b000};
            default: dur = {1'b0, len_eff, 4'b0000};
        endcase
    end

    // Next state and judgement of the current cycle; abort overrides both.
    always_comb begin
        state_nx = state;
        judge_ev = J_NONE;
        case (state)
            IDLE, DONE: begin
                if (start_ok) state_nx = (song_len == {ADDR_W{1'b0}}) ? DONE : FETCH;
                else state_nx = state;
            end
            FETCH: state_nx = WAIT;
            WAIT:  state_nx = PLAY;
            PLAY: begin
                if (hit && !judged && (note_r != 4'd0)) begin
                    if (hit_note != note_r) judge_ev = J_MISS;
                    else if (elapsed <= WIN_P) judge_ev = J_PERFECT;
                    else if (elapsed <= WIN_G) judge_ev = J_GOOD;
                    else judge_ev = J_MISS;
                end else if (note_end && !judged && (note_r != 4'd0)) begin
                    judge_ev = J_MISS;
                end else begin
                    judge_ev = J_NONE;
                end
                if (note_end) state_nx = (rom_addr == len_r - ADDR_W'(1)) ? DONE : FETCH;
                else state_nx = PLAY;
            end
            default: state_nx = IDLE;
        endcase
        if (abort_ok) judge_ev = J_NONE;
        else judge_ev = judge_ev;
    end

    // Result counters: cleared on start, updated by the judgement, saturating.
    always_comb begin
        judge_n = judge;
        score_n = score;
        combo_n = combo;
        max_n   = max_combo;
        if (start_ok) begin
            judge_n = J_NONE;
            score_n = {SCORE_W{1'b0}};
            combo_n = {SCORE_W{1'b0}};
            max_n   = {SCORE_W{1'b0}};
        end else begin
            case (judge_ev)
                J_PERFECT: begin
                    judge_n = J_PERFECT;
                    score_n = sat_add(score, 2'd3);
                    combo_n = sat_add(combo, 2'd1);
                end
                J_GOOD: begin
                    judge_n = J_GOOD;
                    score_n = sat_add(score, 2'd1);
                    combo_n = sat_add(combo, 2'd1);
                end
                J_MISS: begin
                    judge_n = J_MISS;
                    combo_n = {SCORE_W{1'b0}};
                end
                default: judge_n = judge;
            endcase
            max_n = (combo_n > max_combo) ? combo_n : max_combo;
        end
    end

    // State register, note sequencing and tick timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rom_addr  <= {ADDR_W{1'b0}};
            mode_r    <= 2'b00;
            len_r     <= {ADDR_W{1'b0}};
            length_r  <= 4'd0;
            note_r    <= 4'd0;
            presc     <= {PW{1'b0}};
            elapsed   <= {EW{1'b0}};
            judged    <= 1'b0;
            judge     <= J_NONE;
            score     <= {SCORE_W{1'b0}};
            combo     <= {SCORE_W{1'b0}};
            max_combo <= {SCORE_W{1'b0}};
        end else begin
            state     <= state_n;
            judge     <= judge_n;
            score     <= score_n;
            combo     <= combo_n;
            max_combo <= max_n;
            if (abort_ok) begin
                note_r <= 4'd0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start_ok) begin
                            mode_r   <= mode;
                            len_r    <= song_len;
                            rom_addr <= {ADDR_W{1'b0}};
                        end
                    end
                    WAIT: begin
                        note_r   <= rom_data[7:4];
                        length_r <= rom_data[3:0];
                        presc    <= {PW{1'b0}};
                        elapsed  <= {EW{1'b0}};
                        judged   <= 1'b0;
                    end
                    PLAY: begin
                        presc <= tick ? {PW{1'b0}} : presc + PW'(1);
                        if (tick) elapsed <= elapsed + EW'(1);
                        if (judge_ev != J_NONE) judged <= 1'b1;
                        if (state_nx == FETCH) rom_addr <= rom_addr + ADDR_W'(1);
                        if (state_nx == DONE) note_r <= 4'd0;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef PLAY_HISCORE_EN
    logic [USER_W-1:0]  user_r, user_n;
    logic [SCORE_W-1:0] hs_table [2**USER_W];
    logic               enter_done;

    assign user_n     = start_ok ? user : user_r;
    assign enter_done = (state_n == DONE) && ((state != DONE) || start_ok);
    assign hi_score   = hs_table[user_r];

    // High-score table: best final score per user, written as DONE is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            user_r <= {USER_W{1'b0}};
            for (int i = 0; i < 2**USER_W; i++) hs_table[i] <= {SCORE_W{1'b0}};
        end else begin
            user_r <= user_n;
            if (enter_done && (score_n > hs_table[user_n])) hs_table[user_n] <= score_n;
        end
    end
`else
    logic unused_user;
    assign unused_user = ^user;
    assign hi_score    = {SCORE_W{1'b0}};
`endif

endmodule

// File: tb/tb_play_engine.sv
// Scoreboard bench for play_engine: a full-width instance and a SCORE_W=2 instance run in lockstep.
`timescale 1ns/1ps
module tb_play_engine;
    localparam int USER_W = 3;
    localparam int ADDR_W = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, start, abort, hit;
    logic [USER_W-1:0] user;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] song_len;
    logic [3:0]        hit_note;
    logic [7:0]        rom [0:63];

    logic [ADDR_W-1:0] rom_addr, rom_addr_s;
    logic [7:0]        rom_data, rom_data_s;
    logic [3:0]        cur_note, cur_note_s;
    logic              busy, done, busy_s, done_s;
    logic [1:0]        judge, judge_s;
    logic [20:0]       score, combo, max_combo, hi_score;
    logic [1:0]        score_s, combo_s, max_combo_s, hi_score_s;

    play_engine #(.TICK_DIV(1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .user(user), .mode(mode),
        .song_len(song_len), .rom_addr(rom_addr), .rom_data(rom_data), .hit(hit),
        .hit_note(hit_note), .cur_note(cur_note), .busy(busy), .done(done), .judge(judge),
        .score(score), .combo(combo), .max_combo(max_combo), .hi_score(hi_score)
    );

    play_engine #(.TICK_DIV(1), .SCORE_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .user(user), .mode(mode),
        .song_len(song_len), .rom_addr(rom_addr_s), .rom_data(rom_data_s), .hit(hit),
        .hit_note(hit_note), .cur_note(cur_note_s), .busy(busy_s), .done(done_s), .judge(judge_s),
        .score(score_s), .combo(combo_s), .max_combo(max_combo_s), .hi_score(hi_score_s)
    );

    always @(posedge clk) begin
        rom_data   <= rom[rom_addr];
        rom_data_s <= rom[rom_addr_s];
    end

    typedef struct { int judge; int score; int combo; int maxc; int hi; } exp_t;
    exp_t q[$];
    exp_t me;
    int checks = 0;
    int errors = 0;

    function automatic int hi_exp(input int v);
`ifdef PLAY_HISCORE_EN
        return v;
`else
        return 0;
`endif
    endfunction

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int j, input int s, input int c, input int m, input int h);
        exp_t e;
        e.judge = j; e.score = s; e.combo = c; e.maxc = m; e.hi = h;
        q.push_back(e);
    endtask

    // Monitor: a song result is presented when busy falls or done rises.
    logic busy_q, done_q;
    always @(negedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if ((busy_q && !busy) || (!done_q && done)) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got an end-of-song event, expected none");
                end else begin
                    me = q.pop_front();
                    check("judge", int'(judge), me.judge);
                    check("score", int'(score), me.score);
                    check("combo", int'(combo), me.combo);
                    check("max_combo", int'(max_combo), me.maxc);
                    check("hi_score", int'(hi_score), me.hi);
                    check("sat_score", int'(score_s), sat3(me.score));
                    check("sat_combo", int'(combo_s), sat3(me.combo));
                    check("sat_max_combo", int'(max_combo_s), sat3(me.maxc));
                    check("sat_hi_score", int'(hi_score_s), sat3(me.hi));
                end
            end
            busy_q <= busy;
            done_q <= done;
        end
    end

    task automatic start_song(input int u, input int m, input int len);
        @(negedge clk);
        user = USER_W'(u); mode = 2'(m); song_len = ADDR_W'(len); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_note(input int n);
        int k = 0;
        while (cur_note != 4'(n) && k < 2000) begin @(negedge clk); k++; end
        if (k >= 2000) begin
            checks++; errors++;
            $display("FAIL wait_note: got cur_note %0d, expected %0d", cur_note, n);
        end
    endtask

    task automatic hit_at(input int n, input int k);
        repeat (k) @(negedge clk);
        hit = 1'b1; hit_note = 4'(n);
        @(negedge clk);
        hit = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 5000) begin @(negedge clk); k++; end
        if (k >= 5000) begin
            checks++; errors++;
            $display("FAIL wait_idle: got busy 1, expected 0");
        end
        @(negedge clk);
    endtask

    task automatic load_song3();
        rom[0] = 8'h54; rom[1] = 8'h02; rom[2] = 8'h31;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; hit = 1'b0;
        user = '0; mode = 2'b00; song_len = '0; hit_note = 4'd0;
        for (int i = 0; i < 64; i++) rom[i] = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_rom_addr", int'(rom_addr), 0);
        check("rst_cur_note", int'(cur_note), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_judge", int'(judge), 0);
        check("rst_score", int'(score), 0);
        check("rst_max_combo", int'(max_combo), 0);
        check("rst_hi_score", int'(hi_score), 0);
        rst = 1'b0;

        // two Perfects, user 2 -> 6
        load_song3();
        push(3, 6, 2, 2, hi_exp(6));
        start_song(2, 0, 3);
        wait_note(5); hit_at(5, 2);
        check("t1_first_judge", int'(judge), 3);
        check("t1_first_score", int'(score), 3);
        wait_note(3); hit_at(3, 5);
        wait_idle();

        // Good then Miss
        push(1, 1, 0, 1, hi_exp(6));
        start_song(2, 0, 3);
        wait_note(5); hit_at(5, 15);
        check("t2_good_judge", int'(judge), 2);
        wait_idle();

        // double time, hit on the note-end cycle is Perfect; user 2 scores 3
        rom[0] = 8'h21;
        push(3, 3, 1, 1, hi_exp(6));
        start_song(2, 3, 1);
        wait_note(2); hit_at(2, 8);
        wait_idle();

        // wrong note then correct note: one Miss only
        rom[0] = 8'h54;
        push(1, 0, 0, 0, 0);
        start_song(3, 0, 1);
        wait_note(5); hit_at(6, 1);
        check("t4_wrong_judge", int'(judge), 1);
        hit_at(5, 1);
        check("t4_later_hit_score", int'(score), 0);
        check("t4_later_hit_judge", int'(judge), 1);
        wait_idle();

        // user 2 reaches 9 then aborts (with a simultaneous hit): no table update
        rom[0] = 8'h11; rom[1] = 8'h21; rom[2] = 8'h31; rom[3] = 8'h41;
        push(3, 9, 3, 3, hi_exp(6));
        start_song(2, 3, 4);
        wait_note(1); hit_at(1, 0);
        wait_note(2); hit_at(2, 0);
        wait_note(3); hit_at(3, 0);
        wait_note(4);
        repeat (2) @(negedge clk);
        abort = 1'b1; hit = 1'b1; hit_note = 4'd4;
        @(negedge clk);
        abort = 1'b0; hit = 1'b0;
        check("t5_abort_cur_note", int'(cur_note), 0);
        check("t5_abort_busy", int'(busy), 0);
        check("t5_abort_score", int'(score), 9);
        @(negedge clk);

        // empty song: DONE one cycle after start; user 1 reads 0
        push(0, 0, 0, 0, 0);
        start_song(1, 0, 0);
        check("t6_done", int'(done), 1);
        check("t6_busy", int'(busy), 0);
        check("t6_hi_user1", int'(hi_score), 0);
        @(negedge clk);

        // start while busy is ignored
        load_song3();
        push(0, 0, 0, 0, hi_exp(6));
        start_song(2, 0, 3);
        wait_note(5);
        start_song(1, 3, 0);
        check("t7_busy_kept", int'(busy), 1);
        check("t7_note_kept", int'(cur_note), 5);
        check("t7_done_low", int'(done), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);

        // reset mid-song, then user 2 entry must read 0
        start_song(2, 0, 3);
        wait_note(5); hit_at(5, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t8_rst_busy", int'(busy), 0);
        check("t8_rst_score", int'(score), 0);
        check("t8_rst_combo", int'(combo), 0);
        check("t8_rst_cur_note", int'(cur_note), 0);
        check("t8_rst_rom_addr", int'(rom_addr), 0);
        rst = 1'b0;
        push(0, 0, 0, 0, 0);
        start_song(2, 0, 0);
        check("t8_hi_user2", int'(hi_score), 0);
        repeat (2) @(negedge clk);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_results: got %0d unseen, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
